video_timing_gen: RTL and testbench



---
 rtl/video_timing_if.sv | 14 +
 rtl/video_timing_gen.sv | 88 ++++++++
 tb/tb_video_timing_gen.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/video_timing_if.sv
// Raster timing bundle: pixel-fetch request position plus delayed encoder controls.
interface video_timing_if;
  logic        req_de;
  logic [11:0] req_x;
  logic [11:0] req_y;
  logic        frame_start;
  logic        line_start;
  logic        vde;
  logic        hsync;
  logic        vsync;

  modport master (output req_de, req_x, req_y, frame_start, line_start, vde, hsync, vsync);
  modport slave  (input  req_de, req_x, req_y, frame_start, line_start, vde, hsync, vsync);
endinterface

// File: rtl/video_timing_gen.sv
// Raster timing generator: h/v counters, registered fetch position, and
// sync/data-enable delayed by PIPE_DLY to align with returned pixel data.
module video_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0,
  parameter int PIPE_DLY = 2
) (
  input  logic           clk,
  input  logic           rst,
  video_timing_if.master vt
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // 13-bit bounds so a sync window ending exactly at 4096 still compares correctly
  localparam logic [12:0] H_ACT  = 13'(H_ACTIVE);
  localparam logic [12:0] HS_BEG = 13'(H_ACTIVE + H_FP);
  localparam logic [12:0] HS_END = 13'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [12:0] H_LAST = 13'(H_TOTAL - 1);
  localparam logic [12:0] V_ACT  = 13'(V_ACTIVE);
  localparam logic [12:0] VS_BEG = 13'(V_ACTIVE + V_FP);
  localparam logic [12:0] VS_END = 13'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [12:0] V_LAST = 13'(V_TOTAL - 1);
  localparam logic        HS_ON  = 1'(HS_POL);
  localparam logic        VS_ON  = 1'(VS_POL);

  if (H_TOTAL > 4096 || V_TOTAL > 4096) begin : g_bad_total
    $error("video_timing_gen: H_TOTAL/V_TOTAL must not exceed 4096");
  end
  if (PIPE_DLY < 0 || PIPE_DLY > 15) begin : g_bad_dly
    $error("video_timing_gen: PIPE_DLY must be 0..15");
  end

  typedef struct packed {
    logic de;
    logic hs;
    logic vs;
  } raster_t;

  logic [11:0] h_cnt, v_cnt;
  logic [12:0] h_ext, v_ext;
  logic        de_raw, hs_raw, vs_raw, h_wrap, v_wrap;
  raster_t [PIPE_DLY:0] dly_pipe;

  assign h_ext  = {1'b0, h_cnt};
  assign v_ext  = {1'b0, v_cnt};
  assign de_raw = (h_ext < H_ACT) && (v_ext < V_ACT);
  assign hs_raw = (h_ext >= HS_BEG) && (h_ext < HS_END);
  assign vs_raw = (v_ext >= VS_BEG) && (v_ext < VS_END);
  assign h_wrap = (h_ext == H_LAST);
  assign v_wrap = (v_ext == V_LAST);

  // Counters hold the position presented on the next edge; req_* register it.
  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt          <= '0;
      v_cnt          <= '0;
      dly_pipe       <= '0;
      vt.req_de      <= 1'b0;
      vt.req_x       <= '0;
      vt.req_y       <= '0;
      vt.frame_start <= 1'b0;
      vt.line_start  <= 1'b0;
    end else begin
      h_cnt <= h_wrap ? '0 : h_cnt + 12'd1;
      if (h_wrap) v_cnt <= v_wrap ? '0 : v_cnt + 12'd1;
      vt.req_de      <= de_raw;
      vt.req_x       <= h_cnt;
      vt.req_y       <= v_cnt;
      vt.frame_start <= (h_cnt == 12'd0) && (v_cnt == 12'd0);
      vt.line_start  <= (h_cnt == 12'd0) && (v_ext < V_ACT);
      dly_pipe[0]    <= '{de: de_raw, hs: hs_raw, vs: vs_raw};
      for (int i = 1; i <= PIPE_DLY; i++) dly_pipe[i] <= dly_pipe[i-1];
    end
  end

  assign vt.vde   = dly_pipe[PIPE_DLY].de;
  assign vt.hsync = dly_pipe[PIPE_DLY].hs ? HS_ON : ~HS_ON;
  assign vt.vsync = dly_pipe[PIPE_DLY].vs ? VS_ON : ~VS_ON;
endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench: default 640x480, a tiny raster for frame-level checks, and 720p.
module tb_video_timing_gen;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  video_timing_if vif_a ();
  video_timing_if vif_b ();
  video_timing_if vif_c ();

  video_timing_gen u_a (.clk(clk), .rst(rst), .vt(vif_a));

  video_timing_gen #(
    .H_ACTIVE(1280), .H_FP(110), .H_SYNC(40), .H_BP(220),
    .V_ACTIVE(720),  .V_FP(5),   .V_SYNC(5),  .V_BP(20),
    .HS_POL(1), .VS_POL(1), .PIPE_DLY(0)
  ) u_b (.clk(clk), .rst(rst), .vt(vif_b));

  // 16 x 12 raster, 192 cycles per frame
  video_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(3),
    .HS_POL(0), .VS_POL(1), .PIPE_DLY(3)
  ) u_c (.clk(clk), .rst(rst), .vt(vif_c));

  int n_run  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  int cnt_a, cnt_b, cnt_c, cnt_d, first_a, first_b, last_a;

  initial begin
    // ---------------- defaults 640x480, PIPE_DLY=2 ----------------
    rst = 1'b1;
    repeat (5) tick();
    chk("a_rst_de",    vif_a.req_de, 0);
    chk("a_rst_vde",   vif_a.vde, 0);
    chk("a_rst_hsync", vif_a.hsync, 1);
    chk("a_rst_vsync", vif_a.vsync, 1);
    chk("a_rst_x",     vif_a.req_x, 0);
    chk("a_rst_y",     vif_a.req_y, 0);
    chk("a_rst_fs",    vif_a.frame_start, 0);
    rst = 1'b0;
    cnt_a = 0; cnt_b = 0; cnt_c = 0; cnt_d = 0; first_a = -1; first_b = -1;
    for (int k = 1; k <= 1602; k++) begin
      tick();
      if (k == 1) begin
        chk("a_k1_fs", vif_a.frame_start, 1);
        chk("a_k1_x",  vif_a.req_x, 0);
        chk("a_k1_y",  vif_a.req_y, 0);
        chk("a_k1_de", vif_a.req_de, 1);
        chk("a_k1_ls", vif_a.line_start, 1);
        chk("a_k1_vde", vif_a.vde, 0);
      end
      if (k == 2) chk("a_k2_vde", vif_a.vde, 0);
      if (k == 3) chk("a_k3_vde", vif_a.vde, 1);
      if (k <= 800) begin
        if (vif_a.req_de) cnt_a++;
        else if (first_a < 0) first_a = int'(vif_a.req_x);
        if (!vif_a.hsync) begin
          cnt_b++;
          if (first_b < 0) first_b = int'(vif_a.req_x);
        end
      end
      if (k >= 3 && k <= 802 && vif_a.vde) cnt_c++;
      if (k <= 1600 && vif_a.line_start) cnt_d++;
      if (!vif_a.vsync) chk("a_vsync_line01", vif_a.vsync, 1);
      if (k == 800) begin
        chk("a_eol_x", vif_a.req_x, 799);
        chk("a_eol_y", vif_a.req_y, 0);
      end
      if (k == 801) begin
        chk("a_sol_x",  vif_a.req_x, 0);
        chk("a_sol_y",  vif_a.req_y, 1);
        chk("a_sol_ls", vif_a.line_start, 1);
        chk("a_sol_fs", vif_a.frame_start, 0);
      end
    end
    chk("a_de_count",     cnt_a, 640);
    chk("a_de_first_low", first_a, 640);
    chk("a_hs_low_count", cnt_b, 96);
    chk("a_hs_first_x",   first_b, 658);
    chk("a_vde_count",    cnt_c, 640);
    chk("a_ls_count",     cnt_d, 2);

    // ---------------- tiny raster 16x12, PIPE_DLY=3 ----------------
    rst = 1'b1;
    repeat (2) tick();
    chk("c_rst_vsync", vif_c.vsync, 0);
    chk("c_rst_hsync", vif_c.hsync, 1);
    rst = 1'b0;
    cnt_a = 0; cnt_b = 0; cnt_c = 0; cnt_d = 0; first_a = -1; first_b = -1; last_a = 0;
    for (int k = 1; k <= 400; k++) begin
      tick();
      if (vif_c.frame_start) begin
        if (first_a < 0) first_a = k;
        else if (first_b < 0) first_b = k;
        last_a++;
      end
      if (k >= 4 && k <= 195) begin
        if (vif_c.vde) cnt_a++;
        if (vif_c.vsync) cnt_b++;
        if (!vif_c.hsync) cnt_c++;
      end
      if (k <= 192 && vif_c.line_start) cnt_d++;
      if (k == 96) begin
        chk("c_l5_x", vif_c.req_x, 15);
        chk("c_l5_y", vif_c.req_y, 5);
      end
      if (k == 97) begin
        chk("c_l6_y",  vif_c.req_y, 6);
        chk("c_l6_ls", vif_c.line_start, 0);
        chk("c_l6_de", vif_c.req_de, 0);
      end
      if (k == 192) begin
        chk("c_eof_x", vif_c.req_x, 15);
        chk("c_eof_y", vif_c.req_y, 11);
      end
      if (k == 193) begin
        chk("c_wrap_x",  vif_c.req_x, 0);
        chk("c_wrap_y",  vif_c.req_y, 0);
        chk("c_wrap_fs", vif_c.frame_start, 1);
      end
    end
    chk("c_fs_first",  first_a, 1);
    chk("c_fs_second", first_b, 193);
    chk("c_fs_count",  last_a, 3);
    chk("c_vde_count", cnt_a, 48);
    chk("c_vs_count",  cnt_b, 32);
    chk("c_hs_count",  cnt_c, 36);
    chk("c_ls_count",  cnt_d, 6);

    // mid-frame reset while sync pulses sit in the delay line
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 1; k <= 140; k++) tick();
    chk("c_pre_x", vif_c.req_x, 11);
    chk("c_pre_y", vif_c.req_y, 8);
    chk("c_pre_vsync", vif_c.vsync, 1);
    rst = 1'b1;
    tick();
    chk("c_mr_de",    vif_c.req_de, 0);
    chk("c_mr_x",     vif_c.req_x, 0);
    chk("c_mr_y",     vif_c.req_y, 0);
    chk("c_mr_fs",    vif_c.frame_start, 0);
    chk("c_mr_ls",    vif_c.line_start, 0);
    chk("c_mr_vde",   vif_c.vde, 0);
    chk("c_mr_hsync", vif_c.hsync, 1);
    chk("c_mr_vsync", vif_c.vsync, 0);
    rst = 1'b0;
    cnt_a = 0; first_a = -1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k == 1) begin
        chk("c_rs_fs", vif_c.frame_start, 1);
        chk("c_rs_x",  vif_c.req_x, 0);
        chk("c_rs_y",  vif_c.req_y, 0);
      end
      if (k == 3) chk("c_rs_vde3", vif_c.vde, 0);
      if (k == 4) chk("c_rs_vde4", vif_c.vde, 1);
      if (vif_c.vsync) cnt_a++;
      if (!vif_c.hsync && first_a < 0) first_a = k;
    end
    chk("c_rs_no_vsync", cnt_a, 0);
    chk("c_rs_hs_first", first_a, 14);

    // ---------------- 1280x720p, PIPE_DLY=0, active-high syncs ----------------
    rst = 1'b1;
    repeat (2) tick();
    chk("b_rst_hsync", vif_b.hsync, 0);
    chk("b_rst_vsync", vif_b.vsync, 0);
    chk("b_rst_vde",   vif_b.vde, 0);
    rst = 1'b0;
    cnt_a = 0; cnt_b = 0; cnt_c = 0; first_a = -1; last_a = -1;
    for (int k = 1; k <= 3300; k++) begin
      tick();
      if (k == 1) chk("b_k1_vde", vif_b.vde, 1);
      if (vif_b.vde !== vif_b.req_de) cnt_a++;
      if (k <= 1650 && vif_b.hsync) begin
        cnt_b++;
        if (first_a < 0) first_a = int'(vif_b.req_x);
        last_a = int'(vif_b.req_x);
      end
      if (vif_b.vsync) cnt_c++;
      if (k == 1650) chk("b_eol_x", vif_b.req_x, 1649);
      if (k == 1651) begin
        chk("b_sol_x", vif_b.req_x, 0);
        chk("b_sol_y", vif_b.req_y, 1);
      end
    end
    chk("b_vde_eq_de",  cnt_a, 0);
    chk("b_hs_count",   cnt_b, 40);
    chk("b_hs_first_x", first_a, 1390);
    chk("b_hs_last_x",  last_a, 1429);
    chk("b_vs_count",   cnt_c, 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
